text_console_writer: RTL and testbench
======================================

# text_console_writer

Character-stream front end for the text-mode video path: accepts one ASCII byte per handshake and writes the matching code point/attribute cell into the video BRAM's CPU-side write port. It tracks a cursor, handles control characters, auto-wraps, and blanks whole lines and the screen in hardware. It drives the video BRAM's `cpu_*` port directly, so the character stream can be shown without CPU involvement.

## Interface

Parameters:
- `COLS`, 160, text columns (1280 px / 8 px font); must be even
- `ROWS`, 45, text rows (720 px / 16 px font)
- `BASE_ADDR`, 32'h0000_0000, byte address of cell (0,0) in video BRAM
- `DEFAULT_ATTR`, 8'h0F, attribute loaded at reset

Ports:
- `clk_in` input 1: single clock, all logic rising-edge
- `rst_in` input 1: asynchronous, active-high reset
- `char_valid_in` input 1: `char_in` is valid
- `char_in` input 8: ASCII byte
- `ready_out` output 1: block can accept a character this cycle
- `attr_valid_in` input 1: load `attr_in` as current attribute
- `attr_in` input 8: attribute byte
- `clear_in` input 1: clear request (sampled only while `ready_out`=1)
- `mem_addr_out` output 32: word-aligned byte address to video BRAM
- `mem_data_out` output 32: write data, `{attr,cp,attr,cp}`
- `mem_write_enable_out` output 4: byte-lane write strobes
- `cursor_col_out` output $clog2(COLS): current column
- `cursor_row_out` output $clog2(ROWS): current row

## Operation

- Cell layout: 16 bits per cell, `{attribute, code_point}`; two cells per 32-bit word. Cell index `i = row*COLS + col`; word address `BASE_ADDR + (i>>1)*4`; even `i` → strobe 4'b0011, odd `i` → 4'b1100.
- States: `CLR_SCREEN`, `IDLE`, `CLR_LINE`. `ready_out` = 1 only in `IDLE`.
- Accept = `char_valid_in & ready_out & ~clear_in`.
- In `IDLE`, on accept:
  - 0x20–0x7E: write cell at cursor with current attribute. If col < COLS-1, col+1 and stay in `IDLE`. Otherwise col=0, row advances, go to `CLR_LINE`.
  - 0x0A (LF): col=0, row advances, go to `CLR_LINE`.
  - 0x0D (CR): col=0, no write.
  - 0x08 (BS): col-1 if col>0, otherwise no change. No write.
  - Any other byte: ignored (consumed, no write, cursor unchanged).
- Row advance: row+1, wrapping from ROWS-1 to 0. Scrolling is circular; no BRAM copy.
- `CLR_LINE`: writes COLS/2 words covering the new cursor row, strobe 4'b1111, data `{A,8'h20,A,8'h20}`. Returns to `IDLE` after the last word.
- `CLR_SCREEN`: writes ROWS*COLS/2 words from word 0 upward with the same data, then sets cursor (0,0) and goes to `IDLE`.
  - Entered on reset.
  - Entered when `clear_in`=1 while in `IDLE`. `clear_in` has priority over a simultaneous char; that char is not consumed.
- Attribute `A` used by a clear is captured at clear entry.
- `attr_valid_in` loads the current attribute in any state, including busy states. It affects only chars accepted after that edge. If it coincides with an accept, the accepted char uses the old attribute.

## Timing

- Reset values, applied immediately and asynchronously:
  - state `CLR_SCREEN`, cursor (0,0), attribute `DEFAULT_ATTR`
  - `ready_out`=0, `mem_write_enable_out`=0, `mem_addr_out`=0, `mem_data_out`=0
- First clear write appears in the first cycle after reset deasserts. Reset mid-operation aborts any clear and restarts the full-screen clear.
- All `mem_*` outputs are registered. A char accepted at edge N produces its write in cycle N+1, a one-cycle strobe. Strobe is 0 in any cycle with no write.
- Back-to-back printable chars within a row: one accept and one write per cycle, `ready_out` held high.
- LF or wrap accepted at edge N: `ready_out`=0 from cycle N+1. Clear writes occur in cycles N+1 … N+COLS/2. `ready_out`=1 in cycle N+COLS/2+1.
- Wrapping printable at col COLS-1: its char write occurs in cycle N+1 and the line clear starts at N+2. `ready_out` returns at N+COLS/2+2.
- Full clear: ROWS*COLS/2 write cycles (3600 at defaults), then `ready_out`=1.
- Cursor outputs update on the accept edge; the post-clear (0,0) cursor takes effect at clear completion.

## Test plan

- Reset, then wait: 3600 writes, word addresses 0x0…0x383C, strobe 4'hF, data 32'h0F20_0F20. Then `ready_out`=1 and cursor (0,0).
- Send "AB" back-to-back: write addr 0x0 / strobe 4'b0011 / data[15:0]=16'h0F41, then addr 0x0 / strobe 4'b1100 / data[31:16]=16'h0F42. Cursor ends at (2,0).
- Set `attr_in`=8'h1E, then send 161 'x' characters. Write 160 lands at addr 0x13C with strobe 4'b1100. Then 80 row-1 clear writes at 0x140…0x27C with data 32'h1E20_1E20. Write 161 lands at addr 0x140, and cursor ends at (1,1).
- At cursor (5,44), send LF: row wraps to 0, 80 clear writes at 0x0…0x13C, cursor (0,0). Then send BS: cursor stays (0,0) with no write. Then CR: no write.
- In the same cycle assert `clear_in` and `char_valid_in`='Q': no 'Q' write occurs and a full clear runs. Asserting `rst_in` midway through that clear drops the strobe immediately, and a full 3600-write clear restarts after release.

Source files
------------

// File: rtl/text_console_writer.sv
// text_console_writer: turns a handshaked ASCII byte stream into code point/attribute
// cell writes on the video BRAM CPU port. Keeps the cursor, handles BS/CR/LF, wraps at
// the right margin, and blanks the new line on a line feed or wrap, or the whole
// screen on reset or on a clear request.
module text_console_writer #(
    parameter int unsigned COLS         = 160,
    parameter int unsigned ROWS         = 45,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter logic [7:0]  DEFAULT_ATTR = 8'h0F
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    char_valid_in,
    input  logic [7:0]              char_in,
    output logic                    ready_out,
    input  logic                    attr_valid_in,
    input  logic [7:0]              attr_in,
    input  logic                    clear_in,
    output logic [31:0]             mem_addr_out,
    output logic [31:0]             mem_data_out,
    output logic [3:0]              mem_write_enable_out,
    output logic [$clog2(COLS)-1:0] cursor_col_out,
    output logic [$clog2(ROWS)-1:0] cursor_row_out
);

    localparam int          CW           = $clog2(COLS);
    localparam int          RW           = $clog2(ROWS);
    localparam int unsigned LINE_WORDS   = COLS / 2;
    localparam int unsigned SCREEN_WORDS = ROWS * COLS / 2;
    localparam int          WW           = $clog2(SCREEN_WORDS + 1);

    typedef enum logic [1:0] {
        CLR_SCREEN,
        IDLE,
        CLR_LINE
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_col;
    logic [RW-1:0]   r_row;
    logic [7:0]      r_attr;
    logic [7:0]      r_clr_attr;
    // Index of the next blanking word to write; the clear ends once it reaches the word count.
    logic [WW-1:0]   r_word;
    logic [31:0]     r_addr;
    logic [31:0]     r_data;
    logic [3:0]      r_we;

    logic            w_printable;
    logic [RW-1:0]   w_row_next;
    logic [31:0]     w_cell_word;
    logic [31:0]     w_line_word;
    logic [31:0]     w_next_line_word0;
    logic            w_line_done;
    logic            w_screen_done;

    assign w_printable       = (char_in >= 8'h20) && (char_in <= 8'h7E);
    assign w_row_next        = (r_row == RW'(ROWS - 1)) ? '0 : r_row + RW'(1);
    // Two cells share a word and COLS is even, so the column alone gives word offset and lane.
    assign w_cell_word       = (32'(r_row) * LINE_WORDS) + 32'(r_col >> 1);
    assign w_line_word       = (32'(r_row) * LINE_WORDS) + 32'(r_word);
    assign w_next_line_word0 = 32'(w_row_next) * LINE_WORDS;
    assign w_line_done       = (r_word == WW'(LINE_WORDS));
    assign w_screen_done     = (r_word == WW'(SCREEN_WORDS));

    assign ready_out            = (r_state == IDLE);
    assign mem_addr_out         = r_addr;
    assign mem_data_out         = r_data;
    assign mem_write_enable_out = r_we;
    assign cursor_col_out       = r_col;
    assign cursor_row_out       = r_row;

    // Current attribute: loads in any state; an accept on the same edge still sees the old value.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_attr <= DEFAULT_ATTR;
        end else if (attr_valid_in) begin
            r_attr <= attr_in;
        end
    end

    // Control FSM: cursor tracking, character writes and line/screen blanking, all outputs registered.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state    <= CLR_SCREEN;
            r_col      <= '0;
            r_row      <= '0;
            r_clr_attr <= DEFAULT_ATTR;
            r_word     <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_we       <= '0;
        end else begin
            // NOTE: the strobe default is a non-blocking assignment; a later <= in this block
            // overrides it, so any cycle without a write gets a zero strobe without extra logic.
            r_we <= 4'h0;
            case (r_state)
                CLR_SCREEN: begin
                    if (w_screen_done) begin
                        r_col   <= '0;
                        r_row   <= '0;
                        r_word  <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_addr <= BASE_ADDR + (32'(r_word) << 2);
                        r_data <= {r_clr_attr, 8'h20, r_clr_attr, 8'h20};
                        r_we   <= 4'hF;
                        r_word <= r_word + WW'(1);
                    end
                end

                CLR_LINE: begin
                    if (w_line_done) begin
                        r_word  <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_addr <= BASE_ADDR + (w_line_word << 2);
                        r_data <= {r_clr_attr, 8'h20, r_clr_attr, 8'h20};
                        r_we   <= 4'hF;
                        r_word <= r_word + WW'(1);
                    end
                end

                IDLE: begin
                    if (clear_in) begin
                        // Clear wins over a simultaneous character, which stays unconsumed.
                        r_clr_attr <= r_attr;
                        r_word     <= '0;
                        r_state    <= CLR_SCREEN;
                    end else if (char_valid_in) begin
                        if (w_printable) begin
                            r_addr <= BASE_ADDR + (w_cell_word << 2);
                            r_data <= {r_attr, char_in, r_attr, char_in};
                            r_we   <= r_col[0] ? 4'b1100 : 4'b0011;
                            if (r_col != CW'(COLS - 1)) begin
                                r_col <= r_col + CW'(1);
                            end else begin
                                // Wrap: the char write occupies this cycle, blanking starts next.
                                r_col      <= '0;
                                r_row      <= w_row_next;
                                r_clr_attr <= r_attr;
                                r_word     <= '0;
                                r_state    <= CLR_LINE;
                            end
                        end else if (char_in == 8'h0A) begin
                            // Line feed issues the first blanking word on the accept edge itself.
                            r_col      <= '0;
                            r_row      <= w_row_next;
                            r_clr_attr <= r_attr;
                            r_addr     <= BASE_ADDR + (w_next_line_word0 << 2);
                            r_data     <= {r_attr, 8'h20, r_attr, 8'h20};
                            r_we       <= 4'hF;
                            r_word     <= WW'(1);
                            r_state    <= CLR_LINE;
                        end else if (char_in == 8'h0D) begin
                            r_col <= '0;
                        end else if (char_in == 8'h08) begin
                            if (r_col != '0) begin
                                r_col <= r_col - CW'(1);
                            end
                        end
                    end
                end

                default: begin
                    r_word  <= '0;
                    r_state <= CLR_SCREEN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer at default geometry (160x45, base 0, attr 0x0F).
module tb_text_console_writer;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        char_valid_in = 1'b0;
    logic [7:0]  char_in = 8'h00;
    logic        ready_out;
    logic        attr_valid_in = 1'b0;
    logic [7:0]  attr_in = 8'h00;
    logic        clear_in = 1'b0;
    logic [31:0] mem_addr_out;
    logic [31:0] mem_data_out;
    logic [3:0]  mem_write_enable_out;
    logic [7:0]  cursor_col_out;
    logic [5:0]  cursor_row_out;

    int n_vec = 0;
    int n_err = 0;

    text_console_writer dut (
        .clk_in               (clk_in),
        .rst_in               (rst_in),
        .char_valid_in        (char_valid_in),
        .char_in              (char_in),
        .ready_out            (ready_out),
        .attr_valid_in        (attr_valid_in),
        .attr_in              (attr_in),
        .clear_in             (clear_in),
        .mem_addr_out         (mem_addr_out),
        .mem_data_out         (mem_data_out),
        .mem_write_enable_out (mem_write_enable_out),
        .cursor_col_out       (cursor_col_out),
        .cursor_row_out       (cursor_row_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [7:0]  ch;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] data;
        int          col;
        int          row;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_cursor(input string name, input int col, input int row);
        check({name, " col"}, 32'(cursor_col_out), 32'(col));
        check({name, " row"}, 32'(cursor_row_out), 32'(row));
    endtask

    // Present one character for exactly one edge; returns 1 ns after that edge.
    task automatic send_char(input logic [7:0] c);
        char_valid_in = 1'b1;
        char_in       = c;
        @(posedge clk_in);
        #1;
        char_valid_in = 1'b0;
    endtask

    // Follow a blanking sequence from the current cycle until ready_out rises.
    task automatic run_clear(input string name, input int n_words, input logic [31:0] first_addr,
                             input logic [31:0] exp_data, input int exp_wait);
        int          n_wr   = 0;
        int          n_bad  = 0;
        int          waited = 0;
        logic [31:0] last   = 32'h0;
        bit          to     = 1'b0;
        while (ready_out !== 1'b1) begin
            if (mem_write_enable_out !== 4'h0) begin
                if (mem_write_enable_out !== 4'hF || mem_addr_out !== first_addr + 32'(n_wr) * 4 ||
                    mem_data_out !== exp_data) n_bad++;
                last = mem_addr_out;
                n_wr++;
            end
            if (waited >= 5000) begin
                to = 1'b1;
                break;
            end
            @(posedge clk_in);
            #1;
            waited++;
        end
        check({name, " timeout"}, 32'(to), 32'(0));
        check({name, " write count"}, 32'(n_wr), 32'(n_words));
        check({name, " bad writes"}, 32'(n_bad), 32'(0));
        check({name, " last addr"}, last, first_addr + 32'(n_words - 1) * 4);
        if (exp_wait >= 0) check({name, " busy cycles"}, 32'(waited), 32'(exp_wait));
    endtask

    initial begin
        vecs[0]  = '{8'h41, 4'b0011, 32'h0, 32'h0F41_0F41, 1, 0};
        vecs[1]  = '{8'h42, 4'b1100, 32'h0, 32'h0F42_0F42, 2, 0};
        vecs[2]  = '{8'h43, 4'b0011, 32'h4, 32'h0F43_0F43, 3, 0};
        vecs[3]  = '{8'h08, 4'b0000, 32'h0, 32'h0,         2, 0};
        vecs[4]  = '{8'h44, 4'b0011, 32'h4, 32'h0F44_0F44, 3, 0};
        vecs[5]  = '{8'h0D, 4'b0000, 32'h0, 32'h0,         0, 0};
        vecs[6]  = '{8'h01, 4'b0000, 32'h0, 32'h0,         0, 0};
        vecs[7]  = '{8'h7F, 4'b0000, 32'h0, 32'h0,         0, 0};
        vecs[8]  = '{8'h7E, 4'b0011, 32'h0, 32'h0F7E_0F7E, 1, 0};
        vecs[9]  = '{8'h20, 4'b1100, 32'h0, 32'h0F20_0F20, 2, 0};
        vecs[10] = '{8'h1F, 4'b0000, 32'h0, 32'h0,         2, 0};

        // Reset state, then the power-on screen clear.
        repeat (3) @(posedge clk_in);
        #1;
        check("reset ready", 32'(ready_out), 32'(0));
        check("reset we", 32'(mem_write_enable_out), 32'(0));
        check("reset addr", mem_addr_out, 32'h0);
        check("reset data", mem_data_out, 32'h0);
        check_cursor("reset", 0, 0);
        rst_in = 1'b0;
        run_clear("boot screen", 3600, 32'h0, 32'h0F20_0F20, -1);
        check("boot ready", 32'(ready_out), 32'(1));
        check_cursor("boot", 0, 0);

        // Single-cycle characters within row 0, back to back.
        for (int i = 0; i < 11; i++) begin
            check($sformatf("vec%0d ready", i), 32'(ready_out), 32'(1));
            send_char(vecs[i].ch);
            check($sformatf("vec%0d we", i), 32'(mem_write_enable_out), 32'(vecs[i].we));
            if (vecs[i].we != 4'h0) begin
                check($sformatf("vec%0d addr", i), mem_addr_out, vecs[i].addr);
                check($sformatf("vec%0d data", i), mem_data_out, vecs[i].data);
            end
            check_cursor($sformatf("vec%0d", i), vecs[i].col, vecs[i].row);
        end

        // Attribute load coinciding with an accept: that char keeps the old attribute.
        attr_valid_in = 1'b1;
        attr_in       = 8'h1E;
        send_char(8'h45);
        attr_valid_in = 1'b0;
        check("attr coincide data", mem_data_out, 32'h0F45_0F45);
        send_char(8'h46);
        check("attr new data", mem_data_out, 32'h1E46_1E46);
        check("attr new we", 32'(mem_write_enable_out), 32'(4'b1100));

        // Fill row 0 from column 0 and wrap into row 1.
        send_char(8'h0D);
        begin
            int bad = 0;
            for (int i = 1; i <= 159; i++) begin
                send_char(8'h78);
                if (mem_addr_out !== 32'((i - 1) / 2 * 4) || mem_data_out !== 32'h1E78_1E78 ||
                    mem_write_enable_out !== (((i - 1) % 2 == 1) ? 4'b1100 : 4'b0011)) bad++;
            end
            check("row fill bad writes", 32'(bad), 32'(0));
        end
        check_cursor("col 159", 159, 0);
        send_char(8'h78);
        check("wrap char addr", mem_addr_out, 32'h13C);
        check("wrap char we", 32'(mem_write_enable_out), 32'(4'b1100));
        check("wrap ready low", 32'(ready_out), 32'(0));
        check_cursor("wrap", 0, 1);
        @(posedge clk_in);
        #1;
        run_clear("wrap line", 80, 32'h140, 32'h1E20_1E20, 80);
        send_char(8'h78);
        check("x161 addr", mem_addr_out, 32'h140);
        check("x161 we", 32'(mem_write_enable_out), 32'(4'b0011));
        check_cursor("x161", 1, 1);

        // Walk down to row 44 with line feeds.
        for (int r = 2; r <= 44; r++) begin
            send_char(8'h0A);
            run_clear($sformatf("lf row%0d", r), 80, 32'(r * 320), 32'h1E20_1E20, 80);
        end
        check_cursor("row 44", 0, 44);
        for (int i = 0; i < 5; i++) send_char(8'h61);
        check("row44 addr", mem_addr_out, 32'h3708);
        check("row44 we", 32'(mem_write_enable_out), 32'(4'b0011));
        check_cursor("row44 col5", 5, 44);

        // Line feed on the last row wraps to row 0.
        send_char(8'h0A);
        check_cursor("lf wrap", 0, 0);
        run_clear("lf wrap line", 80, 32'h0, 32'h1E20_1E20, 80);
        send_char(8'h08);
        check("bs col0 we", 32'(mem_write_enable_out), 32'(0));
        check_cursor("bs col0", 0, 0);
        send_char(8'h0D);
        check("cr we", 32'(mem_write_enable_out), 32'(0));
        check_cursor("cr", 0, 0);
        send_char(8'h61);
        check_cursor("pre clear", 1, 0);

        // Clear request beats a simultaneous 'Q'.
        clear_in      = 1'b1;
        char_valid_in = 1'b1;
        char_in       = 8'h51;
        @(posedge clk_in);
        #1;
        clear_in      = 1'b0;
        char_valid_in = 1'b0;
        check("clear no Q write", 32'(mem_write_enable_out), 32'(0));
        check("clear ready low", 32'(ready_out), 32'(0));
        check_cursor("clear entry", 1, 0);
        begin
            int n_wr = 0;
            int bad  = 0;
            for (int i = 0; i < 100; i++) begin
                @(posedge clk_in);
                #1;
                if (mem_write_enable_out !== 4'h0) n_wr++;
                if (mem_write_enable_out !== 4'hF || mem_data_out !== 32'h1E20_1E20 ||
                    mem_addr_out !== 32'(i * 4)) bad++;
            end
            check("partial clear writes", 32'(n_wr), 32'(100));
            check("partial clear bad", 32'(bad), 32'(0));
        end

        // Reset midway through the clear.
        #2;
        rst_in = 1'b1;
        #1;
        check("midrst we", 32'(mem_write_enable_out), 32'(0));
        check("midrst ready", 32'(ready_out), 32'(0));
        check("midrst addr", mem_addr_out, 32'h0);
        check_cursor("midrst", 0, 0);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        run_clear("restart screen", 3600, 32'h0, 32'h0F20_0F20, -1);
        check("restart ready", 32'(ready_out), 32'(1));
        check_cursor("restart", 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
